// File: rtl/avalon_sram_ctrl.sv
// Avalon-MM responder that serves 32-bit word requests from an asynchronous 16-bit SRAM.
// Each word is split into a low and a high halfword access; waitrequest stalls the host until done.
module avalon_sram_ctrl #(
    parameter int SRAM_AW       = 18,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               avn_read,
    input  logic               avn_write,
    input  logic [31:0]        avn_address,
    input  logic [3:0]         avn_byte_enable,
    input  logic [31:0]        avn_writedata,
    output logic [31:0]        avn_readdata,
    output logic               avn_waitrequest,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_write,
    input  logic [15:0]        sram_dq_read,
    output logic               sram_dq_en,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_lb_n,
    output logic               sram_ub_n
);
    localparam int            PW         = $clog2(ACCESS_CYCLES);
    localparam logic [PW-1:0] PHASE_LAST = PW'(ACCESS_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]         state_reg, state_next;
    logic [PW-1:0]      phase_reg, phase_next;
    logic [SRAM_AW-2:0] word_reg, word_next;
    logic [31:0]        wdata_reg, wdata_next;
    logic [3:0]         be_reg, be_next;
    logic               write_reg, write_next;
    logic [31:0]        rdata_reg, rdata_next;

    logic               in_phase;
    logic               upper_half;
    logic               last_phase;
    logic               write_phase;
    logic               read_phase;
    logic [1:0]         half_be;
    logic [1:0]         lane_on;
    logic               unused_addr_bits;

    // Only the word-address bits that reach the SRAM are latched.
    assign unused_addr_bits = ^{avn_address[31:SRAM_AW+1], avn_address[1:0]};

    assign in_phase    = (state_reg == ST_LOW) || (state_reg == ST_HIGH);
    assign upper_half  = (state_reg == ST_HIGH);
    assign last_phase  = (phase_reg == PHASE_LAST);
    assign write_phase = in_phase && write_reg;
    assign read_phase  = in_phase && !write_reg;

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        word_next  = word_reg;
        wdata_next = wdata_reg;
        be_next    = be_reg;
        write_next = write_reg;
        rdata_next = rdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (avn_read || avn_write) begin
                    word_next  = avn_address[SRAM_AW:2];
                    wdata_next = avn_writedata;
                    be_next    = avn_byte_enable;
                    write_next = avn_write;
                    phase_next = '0;
                    // Writes skip any halfword whose byte enables are all clear.
                    if (!avn_write || (avn_byte_enable[1:0] != 2'b00)) begin
                        state_next = ST_LOW;
                    end else if (avn_byte_enable[3:2] != 2'b00) begin
                        state_next = ST_HIGH;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_LOW, ST_HIGH: begin
                if (last_phase) begin
                    phase_next = '0;
                    if (!write_reg) begin
                        if (upper_half) begin
                            rdata_next[31:16] = sram_dq_read;
                        end else begin
                            rdata_next[15:0] = sram_dq_read;
                        end
                    end
                    if (upper_half || (write_reg && (be_reg[3:2] == 2'b00))) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_HIGH;
                    end
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            phase_reg <= '0;
            word_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            write_reg <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            word_reg  <= word_next;
            wdata_reg <= wdata_next;
            be_reg    <= be_next;
            write_reg <= write_next;
            rdata_reg <= rdata_next;
        end
    end

    // Pad strobes come purely from registered state so the SRAM never sees host-side glitches.
    assign half_be = upper_half ? be_reg[3:2] : be_reg[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_on[gi] = read_phase || (write_phase && half_be[gi]);
        end
    endgenerate

    assign sram_addr     = in_phase ? {word_reg, upper_half} : '0;
    assign sram_dq_write = write_phase ? (upper_half ? wdata_reg[31:16] : wdata_reg[15:0]) : 16'h0000;
    assign sram_dq_en    = write_phase;
    assign sram_ce_n     = ~in_phase;
    assign sram_oe_n     = ~read_phase;
    // The final phase cycle releases we_n while address and data are still held.
    assign sram_we_n     = ~(write_phase && !last_phase);
    assign sram_lb_n     = ~lane_on[0];
    assign sram_ub_n     = ~lane_on[1];

    assign avn_waitrequest = (state_reg != ST_DONE);
    assign avn_readdata    = (state_reg == ST_DONE) ? rdata_reg : 32'h0000_0000;

endmodule

// File: tb/tb_avalon_sram_ctrl.sv
// Bench for avalon_sram_ctrl: a transaction-level timeline model plus an SRAM pad model,
// checked every cycle, with hand-computed literal expectations for the directed cases.
module tb_avalon_sram_ctrl;
    localparam int SRAM_AW = 18;
    localparam int N       = 2;

    localparam int F_ADDR = 0;
    localparam int F_DQ   = 1;
    localparam int F_CE   = 2;
    localparam int F_OE   = 3;
    localparam int F_WE   = 4;
    localparam int F_EN   = 5;
    localparam int F_LB   = 6;
    localparam int F_UB   = 7;
    localparam int F_WAIT = 8;
    localparam int F_RD   = 9;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               avn_read = 1'b0;
    logic               avn_write = 1'b0;
    logic [31:0]        avn_address = 32'h0;
    logic [3:0]         avn_byte_enable = 4'h0;
    logic [31:0]        avn_writedata = 32'h0;
    logic [31:0]        avn_readdata;
    logic               avn_waitrequest;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_write;
    logic [15:0]        sram_dq_read;
    logic               sram_dq_en;
    logic               sram_ce_n;
    logic               sram_oe_n;
    logic               sram_we_n;
    logic               sram_lb_n;
    logic               sram_ub_n;

    avalon_sram_ctrl #(.SRAM_AW(SRAM_AW), .ACCESS_CYCLES(N)) dut (
        .clk(clk), .rst(rst),
        .avn_read(avn_read), .avn_write(avn_write), .avn_address(avn_address),
        .avn_byte_enable(avn_byte_enable), .avn_writedata(avn_writedata),
        .avn_readdata(avn_readdata), .avn_waitrequest(avn_waitrequest),
        .sram_addr(sram_addr), .sram_dq_write(sram_dq_write), .sram_dq_read(sram_dq_read),
        .sram_dq_en(sram_dq_en), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        waitreq;
        logic        ce_n, oe_n, we_n, dq_en, lb_n, ub_n;
        logic        chk_addr;
        logic [17:0] addr;
        logic        chk_dq;
        logic [15:0] dq;
        logic        chk_lanes;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] val;
        string       name;
    } lit_t;

    exp_t        exp_q[$];
    lit_t        lit_q[$];
    logic [15:0] ref_mem [0:1023];
    logic [15:0] sram_mem [0:1023];
    bit          preloaded = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic logic [15:0] init_val(input int i);
        if (i == 128) return 16'hBEEF;
        if (i == 129) return 16'hDEAD;
        return 16'(i * 40503) ^ 16'h5AC3;
    endfunction

    // SRAM pads: data only when output-enabled; writes land mid-cycle on active strobes.
    assign sram_dq_read = !sram_oe_n ? sram_mem[sram_addr[9:0]] : 16'hF00D;

    always @(negedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] <= init_val(i);
            preloaded <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) sram_mem[sram_addr[9:0]][7:0]  <= sram_dq_write[7:0];
            if (!sram_ub_n) sram_mem[sram_addr[9:0]][15:8] <= sram_dq_write[15:8];
        end
    end

    function automatic exp_t idle_exp();
        exp_t e;
        e.waitreq = 1'b1; e.ce_n = 1'b1; e.oe_n = 1'b1; e.we_n = 1'b1; e.dq_en = 1'b0;
        e.lb_n = 1'b1; e.ub_n = 1'b1;
        e.chk_addr = 1'b1; e.addr = '0; e.chk_dq = 1'b1; e.dq = '0;
        e.chk_lanes = 1'b1; e.chk_rd = 1'b1; e.rd = '0;
        return e;
    endfunction

    function automatic logic [31:0] fld_val(input int f);
        case (f)
            F_ADDR:  return 32'(sram_addr);
            F_DQ:    return 32'(sram_dq_write);
            F_CE:    return 32'(sram_ce_n);
            F_OE:    return 32'(sram_oe_n);
            F_WE:    return 32'(sram_we_n);
            F_EN:    return 32'(sram_dq_en);
            F_LB:    return 32'(sram_lb_n);
            F_UB:    return 32'(sram_ub_n);
            F_WAIT:  return 32'(avn_waitrequest);
            F_RD:    return avn_readdata;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Single compare process: timeline model every cycle, then any literal expectations due now.
    always @(negedge clk) begin
        exp_t e;
        e = idle_exp();
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("avn_waitrequest", 32'(avn_waitrequest), 32'(e.waitreq));
        chk("sram_ce_n", 32'(sram_ce_n), 32'(e.ce_n));
        chk("sram_oe_n", 32'(sram_oe_n), 32'(e.oe_n));
        chk("sram_we_n", 32'(sram_we_n), 32'(e.we_n));
        chk("sram_dq_en", 32'(sram_dq_en), 32'(e.dq_en));
        if (e.chk_addr) chk("sram_addr", 32'(sram_addr), 32'(e.addr));
        if (e.chk_dq) chk("sram_dq_write", 32'(sram_dq_write), 32'(e.dq));
        if (e.chk_lanes) begin
            chk("sram_lb_n", 32'(sram_lb_n), 32'(e.lb_n));
            chk("sram_ub_n", 32'(sram_ub_n), 32'(e.ub_n));
        end
        if (e.chk_rd) chk("avn_readdata", avn_readdata, e.rd);
        for (int i = lit_q.size() - 1; i >= 0; i--) begin
            if (lit_q[i].cyc == cyc) begin
                chk(lit_q[i].name, fld_val(lit_q[i].fld), lit_q[i].val);
                lit_q.delete(i);
            end
        end
    end

    task automatic lit(input int c, input int f, input logic [31:0] v, input string nm);
        lit_t l;
        l.cyc = c; l.fld = f; l.val = v; l.name = nm;
        lit_q.push_back(l);
    endtask

    // Expected timeline of one accepted request: one entry per cycle after the request cycle.
    task automatic push_sched(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, output int k);
        exp_t        e;
        logic [16:0] w;
        bit          act_h [2];
        int          lo_i, hi_i, idx;
        w = addr[18:2];
        lo_i = int'({w, 1'b0});
        hi_i = int'({w, 1'b1});
        act_h[0] = !wr || (be[1:0] != 2'b00);
        act_h[1] = !wr || (be[3:2] != 2'b00);
        k = 0;
        for (int h = 0; h < 2; h++) begin
            if (act_h[h]) begin
                for (int p = 0; p < N; p++) begin
                    e = idle_exp();
                    e.ce_n = 1'b0;
                    e.oe_n = wr;
                    e.we_n = !wr || (p == N - 1);
                    e.dq_en = wr;
                    e.addr = {w, h[0]};
                    e.chk_dq = wr;
                    e.dq = (h == 0) ? wd[15:0] : wd[31:16];
                    e.lb_n = wr ? !be[2*h] : 1'b0;
                    e.ub_n = wr ? !be[2*h+1] : 1'b0;
                    e.chk_rd = 1'b0;
                    exp_q.push_back(e);
                    k++;
                end
            end
        end
        e = idle_exp();
        e.waitreq = 1'b0; e.chk_addr = 1'b0; e.chk_dq = 1'b0; e.chk_lanes = 1'b0;
        e.chk_rd = !wr;
        e.rd = {ref_mem[hi_i], ref_mem[lo_i]};
        exp_q.push_back(e);
        k++;
        for (int b = 0; b < 4; b++) begin
            if (wr && be[b]) begin
                idx = (b < 2) ? lo_i : hi_i;
                if (b % 2 == 0) ref_mem[idx][7:0] = wd[8*b +: 8];
                else            ref_mem[idx][15:8] = wd[8*b +: 8];
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called one time unit after a clock edge with the DUT idle; returns in the cycle after completion.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input bit hold);
        int k;
        avn_read = rd; avn_write = wr; avn_address = addr;
        avn_byte_enable = be; avn_writedata = wd;
        step(1);
        push_sched(wr, addr, be, wd, k);
        if (!hold) begin
            avn_read = 1'b0; avn_write = 1'b0;
            avn_address = $urandom; avn_writedata = $urandom; avn_byte_enable = 4'($urandom);
        end
        step(k);
        avn_read = 1'b0; avn_write = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          t, k;
        logic [15:0] old_hi;
        logic [31:0] addr, wd;
        logic [3:0]  be;
        logic        rd, wr;
        int          op;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        t = cyc;
        lit(t, F_WAIT, 32'h1, "reset waitrequest");
        lit(t, F_RD, 32'h0, "reset readdata");
        lit(t, F_ADDR, 32'h0, "reset sram_addr");
        lit(t, F_CE, 32'h1, "reset ce_n");
        lit(t, F_EN, 32'h0, "reset dq_en");
        step(1);
        rst = 1'b0;
        step(1);

        // Read of preloaded 0x080/0x081.
        t = cyc;
        lit(t + 1, F_OE, 32'h0, "read oe_n c1");
        lit(t + 4, F_OE, 32'h0, "read oe_n c4");
        lit(t + 1, F_ADDR, 32'h080, "read addr low");
        lit(t + 3, F_ADDR, 32'h081, "read addr high");
        lit(t + 4, F_WAIT, 32'h1, "read wait c4");
        lit(t + 5, F_WAIT, 32'h0, "read wait c5");
        lit(t + 5, F_RD, 32'hDEADBEEF, "read data");
        do_req(1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b1);

        // Full write.
        t = cyc;
        lit(t + 1, F_ADDR, 32'h080, "wr addr low");
        lit(t + 1, F_DQ, 32'hBEEF, "wr dq low");
        lit(t + 1, F_WE, 32'h0, "wr we_n c1");
        lit(t + 2, F_WE, 32'h1, "wr we_n c2");
        lit(t + 3, F_ADDR, 32'h081, "wr addr high");
        lit(t + 3, F_DQ, 32'hDEAD, "wr dq high");
        lit(t + 3, F_WE, 32'h0, "wr we_n c3");
        lit(t + 4, F_WE, 32'h1, "wr we_n c4");
        lit(t + 5, F_WAIT, 32'h0, "wr wait c5");
        do_req(1'b0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b1);

        // Upper-half-only write, be=0x4.
        t = cyc;
        lit(t + 1, F_ADDR, 32'h081, "be4 addr");
        lit(t + 1, F_LB, 32'h0, "be4 lb_n");
        lit(t + 1, F_UB, 32'h1, "be4 ub_n");
        lit(t + 1, F_DQ, 32'h00AA, "be4 dq");
        lit(t + 2, F_WAIT, 32'h1, "be4 wait c2");
        lit(t + 3, F_WAIT, 32'h0, "be4 wait c3");
        do_req(1'b0, 1'b1, 32'h100, 4'h4, 32'h00AA0000, 1'b1);

        // Lower-half-only write, be=0x3.
        t = cyc;
        lit(t + 1, F_ADDR, 32'h082, "be3 addr");
        lit(t + 1, F_DQ, 32'h5678, "be3 dq");
        lit(t + 3, F_WAIT, 32'h0, "be3 wait c3");
        do_req(1'b0, 1'b1, 32'h104, 4'h3, 32'h12345678, 1'b1);

        // be=0 write completes immediately without touching the SRAM.
        t = cyc;
        lit(t + 1, F_WAIT, 32'h0, "be0 wait c1");
        lit(t + 1, F_CE, 32'h1, "be0 ce_n");
        do_req(1'b0, 1'b1, 32'h108, 4'h0, 32'hFFFFFFFF, 1'b1);

        // Back-to-back write then read.
        t = cyc;
        lit(t + 4, F_CE, 32'h0, "b2b ce_n wr end");
        lit(t + 5, F_CE, 32'h1, "b2b ce_n done");
        lit(t + 6, F_CE, 32'h1, "b2b ce_n idle");
        lit(t + 7, F_CE, 32'h0, "b2b ce_n rd start");
        lit(t + 11, F_WAIT, 32'h0, "b2b read wait");
        lit(t + 11, F_RD, 32'hCAFEF00D, "b2b read data");
        do_req(1'b0, 1'b1, 32'h200, 4'hF, 32'hCAFEF00D, 1'b1);
        do_req(1'b1, 1'b0, 32'h200, 4'hF, 32'h0, 1'b1);

        // Reset during the HIGH phase of a write: only the low half reaches the SRAM.
        t = cyc;
        old_hi = ref_mem[513];
        lit(t + 1, F_WE, 32'h0, "abort we_n low phase");
        avn_write = 1'b1; avn_address = 32'h400; avn_byte_enable = 4'hF; avn_writedata = 32'h11223344;
        step(1);
        push_sched(1'b1, 32'h400, 4'hF, 32'h11223344, k);
        ref_mem[513] = old_hi;
        step(2);
        rst = 1'b1;
        exp_q.delete();
        avn_write = 1'b0;
        lit(cyc, F_CE, 32'h1, "abort ce_n");
        lit(cyc, F_WE, 32'h1, "abort we_n");
        lit(cyc, F_EN, 32'h0, "abort dq_en");
        lit(cyc, F_WAIT, 32'h1, "abort waitrequest");
        lit(cyc, F_RD, 32'h0, "abort readdata");
        step(2);
        rst = 1'b0;
        step(1);
        t = cyc;
        lit(t + 4, F_WAIT, 32'h1, "post-reset wait c4");
        lit(t + 5, F_WAIT, 32'h0, "post-reset wait c5");
        lit(t + 5, F_RD, {old_hi, 16'h3344}, "post-reset read");
        do_req(1'b1, 1'b0, 32'h400, 4'hF, 32'h0, 1'b1);

        // Simultaneous read and write is a write.
        t = cyc;
        lit(t + 1, F_EN, 32'h1, "rw dq_en");
        lit(t + 1, F_OE, 32'h1, "rw oe_n c1");
        lit(t + 3, F_OE, 32'h1, "rw oe_n c3");
        do_req(1'b1, 1'b1, 32'h300, 4'hF, 32'h0BADF00D, 1'b1);

        // Randomized traffic against the timeline model.
        for (int i = 0; i < 700; i++) begin
            op = $urandom_range(0, 9);
            rd = (op < 4) || (op >= 8);
            wr = (op >= 4);
            be = 4'($urandom);
            case ($urandom_range(0, 3))
                0: be = be & 4'h3;
                1: be = be & 4'hC;
                default: ;
            endcase
            addr = {13'($urandom), 8'h00, 9'($urandom), 2'($urandom)};
            wd = $urandom;
            do_req(rd, wr, addr, be, wd, ($urandom_range(0, 9) != 0));
            step($urandom_range(0, 2));
        end

        step(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
